// File: rtl/bus_sel_scheduler_pkg.sv
// Shared sizing defaults and fifo ownership state encoding for the bus-select scheduler.
package bus_sel_scheduler_pkg;

    localparam int DEF_PORT_NUM = 12;
    localparam int DEF_DEST_W   = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Successor of a port index, wrapping the last port back to zero.
    function automatic int unsigned wrap_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/bus_sel_scheduler_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping, as one-hot and index.
module bus_sel_scheduler_rr_arb
    import bus_sel_scheduler_pkg::*;
#(
    parameter int N = DEF_PORT_NUM,
    parameter int W = DEF_DEST_W
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [W-1:0] pos_w;

    // Offsets are walked farthest-first so the requester nearest ptr is the last one written.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        pos_w = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos_w = W'((32'(ptr) + 32'(k)) % 32'(N));
            if (req[pos_w]) begin
                gnt        = '0;
                gnt[pos_w] = 1'b1;
                idx        = pos_w;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/bus_sel_scheduler.sv
// Per-fifo round-robin ownership scheduler producing one-hot fd-to-fifo select vectors.
module bus_sel_scheduler
    import bus_sel_scheduler_pkg::*;
#(
    parameter int PORT_NUM = DEF_PORT_NUM,
    parameter int DEST_W   = DEF_DEST_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PORT_NUM-1:0]          req,
    input  logic [PORT_NUM*DEST_W-1:0]   req_dest,
    input  logic [PORT_NUM-1:0]          eop,
    output logic [PORT_NUM-1:0]          grant,
    output logic [PORT_NUM*PORT_NUM-1:0] fd_sel,
    output logic [PORT_NUM-1:0]          port_busy,
    output logic                         dest_err
);

    logic [1:0]                   rst_sync;

    logic [0:0]                   state_q  [PORT_NUM];
    logic [0:0]                   state_d  [PORT_NUM];
    logic [DEST_W-1:0]            owner_q  [PORT_NUM];
    logic [DEST_W-1:0]            owner_d  [PORT_NUM];
    logic [DEST_W-1:0]            ptr_q    [PORT_NUM];
    logic [DEST_W-1:0]            ptr_d    [PORT_NUM];

    logic [PORT_NUM-1:0]          cand     [PORT_NUM];
    logic [PORT_NUM-1:0]          pick_oh  [PORT_NUM];
    logic [DEST_W-1:0]            pick_idx [PORT_NUM];
    logic [PORT_NUM-1:0]          pick_any;

    logic [PORT_NUM-1:0]          fd_owns;
    logic [PORT_NUM-1:0]          dest_bad;
    logic [PORT_NUM-1:0]          grant_d;
    logic [PORT_NUM*PORT_NUM-1:0] fd_sel_d;
    logic                         dest_err_d;

    // Reset asserts asynchronously but is held internally for two more edges after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_sync <= 2'b11;
        end else begin
            rst_sync <= {rst_sync[0], 1'b0};
        end
    end

    always_comb begin
        fd_owns  = '0;
        dest_bad = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            fd_owns[i]  = |fd_sel[i*PORT_NUM +: PORT_NUM];
            dest_bad[i] = req[i] && (32'(req_dest[i*DEST_W +: DEST_W]) >= 32'(PORT_NUM));
        end
    end

    // An fd already holding a fifo is masked out so it can never own two at once.
    always_comb begin
        for (int j = 0; j < PORT_NUM; j++) begin
            cand[j] = '0;
            for (int i = 0; i < PORT_NUM; i++) begin
                cand[j][i] = req[i] && !fd_owns[i] &&
                             (req_dest[i*DEST_W +: DEST_W] == DEST_W'(j));
            end
        end
    end

    for (genvar j = 0; j < PORT_NUM; j++) begin : g_fifo
        bus_sel_scheduler_rr_arb #(
            .N (PORT_NUM),
            .W (DEST_W)
        ) u_arb (
            .req (cand[j]),
            .ptr (ptr_q[j]),
            .gnt (pick_oh[j]),
            .idx (pick_idx[j]),
            .any (pick_any[j])
        );
    end

    always_comb begin
        grant_d    = '0;
        fd_sel_d   = '0;
        dest_err_d = dest_err | (|dest_bad);
        for (int j = 0; j < PORT_NUM; j++) begin
            state_d[j] = state_q[j];
            owner_d[j] = owner_q[j];
            ptr_d[j]   = ptr_q[j];
            if (state_q[j] == ST_IDLE) begin
                if (pick_any[j]) begin
                    state_d[j] = ST_BUSY;
                    owner_d[j] = pick_idx[j];
                    grant_d    = grant_d | pick_oh[j];
                end
            end else if (eop[owner_q[j]]) begin
                state_d[j] = ST_IDLE;
                ptr_d[j]   = DEST_W'(wrap_next(32'(owner_q[j]), PORT_NUM));
            end
            for (int i = 0; i < PORT_NUM; i++) begin
                fd_sel_d[i*PORT_NUM + j] = (state_d[j] == ST_BUSY) && (owner_d[j] == DEST_W'(i));
            end
        end
        if (rst_sync[1]) begin
            grant_d    = '0;
            fd_sel_d   = '0;
            dest_err_d = 1'b0;
            for (int j = 0; j < PORT_NUM; j++) begin
                state_d[j] = ST_IDLE;
                owner_d[j] = '0;
                ptr_d[j]   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant    <= '0;
            fd_sel   <= '0;
            dest_err <= 1'b0;
            for (int j = 0; j < PORT_NUM; j++) begin
                state_q[j] <= ST_IDLE;
                owner_q[j] <= '0;
                ptr_q[j]   <= '0;
            end
        end else begin
            grant    <= grant_d;
            fd_sel   <= fd_sel_d;
            dest_err <= dest_err_d;
            for (int j = 0; j < PORT_NUM; j++) begin
                state_q[j] <= state_d[j];
                owner_q[j] <= owner_d[j];
                ptr_q[j]   <= ptr_d[j];
            end
        end
    end

    always_comb begin
        port_busy = '0;
        for (int j = 0; j < PORT_NUM; j++) begin
            port_busy[j] = (state_q[j] == ST_BUSY);
        end
    end

endmodule

// File: tb/tb_bus_sel_scheduler.sv
// Scoreboard bench: directed request/eop sequences queue expected grants, a negedge monitor checks them.
module tb_bus_sel_scheduler;

    localparam int PN = 12;
    localparam int DW = 4;
    localparam int CW = PN * PN;

    typedef struct {
        int unsigned   cyc;
        logic [PN-1:0] grant;
        logic [CW-1:0] fd_sel;
        logic [PN-1:0] busy;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [PN-1:0]     req;
    logic [PN*DW-1:0]  req_dest;
    logic [PN-1:0]     eop;
    logic [PN-1:0]     grant;
    logic [CW-1:0]     fd_sel;
    logic [PN-1:0]     port_busy;
    logic              dest_err;

    exp_t              exp_q[$];
    exp_t              mon_e;
    int                checks   = 0;
    int                failures = 0;
    int unsigned       cyc      = 0;
    logic [CW-1:0]     identity;

    bus_sel_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_dest  (req_dest),
        .eop       (eop),
        .grant     (grant),
        .fd_sel    (fd_sel),
        .port_busy (port_busy),
        .dest_err  (dest_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [CW-1:0] actual, input logic [CW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [PN-1:0] r, input logic [PN-1:0] e);
        @(negedge clk);
        req = r;
        eop = e;
    endtask

    task automatic setDest(input int fd, input int d);
        req_dest[fd*DW +: DW] = DW'(d);
    endtask

    // The grant is due on the next rising edge, seen by the monitor one cycle from now.
    task automatic expectGrant(input logic [PN-1:0] g, input logic [CW-1:0] sel, input logic [PN-1:0] busy);
        exp_t e;
        e.cyc    = cyc + 1;
        e.grant  = g;
        e.fd_sel = sel;
        e.busy   = busy;
        exp_q.push_back(e);
    endtask

    function automatic logic [PN-1:0] bitv(input int n);
        logic [PN-1:0] v;
        v    = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    function automatic logic [CW-1:0] selBit(input int fd, input int fifo);
        logic [CW-1:0] v;
        v              = '0;
        v[fd*PN + fifo] = 1'b1;
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b0 && grant !== '0) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL grant_unexpected: got %h expected none", grant);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("grant_vec", CW'(grant), CW'(mon_e.grant));
                checkOutput("grant_cycle", CW'(cyc), CW'(mon_e.cyc));
                checkOutput("grant_fd_sel", fd_sel, mon_e.fd_sel);
                checkOutput("grant_busy", CW'(port_busy), CW'(mon_e.busy));
            end
        end
    end

    initial begin
        rst      = 1'b1;
        req      = '0;
        eop      = '0;
        req_dest = '0;
        identity = '0;
        for (int i = 0; i < PN; i++) identity[i*PN + i] = 1'b1;

        repeat (3) @(negedge clk);
        checkOutput("reset_grant", CW'(grant), '0);
        checkOutput("reset_fd_sel", fd_sel, '0);
        checkOutput("reset_busy", CW'(port_busy), '0);
        checkOutput("reset_dest_err", CW'(dest_err), '0);
        rst = 1'b0;
        repeat (3) applyStimulus('0, '0);

        $display("[TB] single request");
        applyStimulus(bitv(2), '0);
        setDest(2, 7);
        expectGrant(bitv(2), selBit(2, 7), bitv(7));
        applyStimulus('0, '0);
        checkOutput("single_sel", fd_sel, selBit(2, 7));
        checkOutput("single_busy", CW'(port_busy), CW'(bitv(7)));
        applyStimulus('0, '0);
        applyStimulus('0, '0);
        applyStimulus('0, bitv(2));
        checkOutput("single_hold", fd_sel, selBit(2, 7));
        applyStimulus('0, '0);
        checkOutput("single_clear_sel", fd_sel, '0);
        checkOutput("single_clear_busy", CW'(port_busy), '0);

        $display("[TB] contention on fifo 1");
        setDest(0, 1);
        setDest(4, 1);
        setDest(9, 1);
        applyStimulus(bitv(0) | bitv(4) | bitv(9), '0);
        expectGrant(bitv(0), selBit(0, 1), bitv(1));
        applyStimulus(bitv(4) | bitv(9), '0);
        applyStimulus(bitv(0) | bitv(4) | bitv(9), bitv(0));
        applyStimulus(bitv(0) | bitv(4) | bitv(9), '0);
        checkOutput("cont_bubble_busy", CW'(port_busy), '0);
        expectGrant(bitv(4), selBit(4, 1), bitv(1));
        applyStimulus(bitv(0) | bitv(9), bitv(4));
        checkOutput("cont_fd4_sel", fd_sel, selBit(4, 1));
        applyStimulus(bitv(0) | bitv(9), '0);
        checkOutput("cont_single_beat_busy", CW'(port_busy), '0);
        expectGrant(bitv(9), selBit(9, 1), bitv(1));
        applyStimulus(bitv(0), '0);
        applyStimulus(bitv(0), bitv(9));
        applyStimulus(bitv(0), '0);
        expectGrant(bitv(0), selBit(0, 1), bitv(1));
        applyStimulus('0, bitv(0));
        applyStimulus('0, '0);
        checkOutput("cont_done_busy", CW'(port_busy), '0);

        $display("[TB] pointer wrap on fifo 0");
        setDest(11, 0);
        applyStimulus(bitv(11), '0);
        expectGrant(bitv(11), selBit(11, 0), bitv(0));
        setDest(0, 0);
        applyStimulus(bitv(0), '0);
        applyStimulus(bitv(0) | bitv(11), bitv(11));
        checkOutput("wrap_owner_sel", fd_sel, selBit(11, 0));
        applyStimulus(bitv(0) | bitv(11), '0);
        checkOutput("wrap_idle_busy", CW'(port_busy), '0);
        expectGrant(bitv(0), selBit(0, 0), bitv(0));
        applyStimulus(bitv(11), bitv(0));
        applyStimulus(bitv(11), '0);
        expectGrant(bitv(11), selBit(11, 0), bitv(0));
        applyStimulus('0, '0);
        applyStimulus('0, bitv(11));
        applyStimulus('0, '0);
        checkOutput("wrap_done_busy", CW'(port_busy), '0);

        $display("[TB] all ports in parallel");
        for (int i = 0; i < PN; i++) setDest(i, i);
        applyStimulus('1, '0);
        expectGrant('1, identity, '1);
        applyStimulus('0, '0);
        checkOutput("par_sel", fd_sel, identity);
        applyStimulus('0, '1);
        applyStimulus('0, '0);
        checkOutput("par_clear_sel", fd_sel, '0);
        checkOutput("par_clear_busy", CW'(port_busy), '0);

        $display("[TB] bad dest, stray eop, withdrawn request");
        setDest(2, 7);
        applyStimulus(bitv(2), '0);
        expectGrant(bitv(2), selBit(2, 7), bitv(7));
        setDest(3, 7);
        setDest(6, 13);
        applyStimulus(bitv(3) | bitv(6), bitv(5));
        checkOutput("err_flag_clear", CW'(dest_err), '0);
        applyStimulus(bitv(6), '0);
        checkOutput("err_flag_set", CW'(dest_err), CW'(1'b1));
        checkOutput("err_stray_eop_sel", fd_sel, selBit(2, 7));
        checkOutput("err_stray_eop_busy", CW'(port_busy), CW'(bitv(7)));
        applyStimulus(bitv(6), bitv(2));
        applyStimulus(bitv(6), '0);
        checkOutput("err_release_busy", CW'(port_busy), '0);
        applyStimulus('0, '0);
        applyStimulus('0, '0);
        checkOutput("err_withdrawn_busy", CW'(port_busy), '0);
        checkOutput("err_flag_sticky", CW'(dest_err), CW'(1'b1));

        $display("[TB] reset mid-grant");
        setDest(3, 5);
        applyStimulus(bitv(3), '0);
        expectGrant(bitv(3), selBit(3, 5), bitv(5));
        applyStimulus('0, '0);
        checkOutput("rst_pre_sel", fd_sel, selBit(3, 5));
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_async_grant", CW'(grant), '0);
        checkOutput("rst_async_sel", fd_sel, '0);
        checkOutput("rst_async_busy", CW'(port_busy), '0);
        checkOutput("rst_async_dest_err", CW'(dest_err), '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) applyStimulus('0, '0);
        applyStimulus(bitv(3), '0);
        expectGrant(bitv(3), selBit(3, 5), bitv(5));
        applyStimulus('0, bitv(3));
        applyStimulus('0, '0);
        checkOutput("rst_after_busy", CW'(port_busy), '0);
        repeat (2) applyStimulus('0, '0);

        checkOutput("pending_grants", CW'(exp_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
